mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port 256 x 16 data memory between the instruction-fetch unit and the load/store unit.
//   The memory port is maddr[7:0], mrd, mwr, mwr_data[7:0], with read data on data[15:0].
//   Each request is arbitrated round-robin and drives a multi-cycle memory access.
//   The block returns registered read data with a one-cycle acknowledge pulse.
//   It sits between the core pipeline and the memory. It is the only master of the memory port.
// PARAMETERS
//   ADDR_W      8   memory address width
//   WDATA_W     8   write-data width (matches mwr_data)
//   RDATA_W     16  read-data width (matches memory data bus)
//   MEM_CYCLES  2   cycles mrd/mwr are held per access; legal range 1..15
// PORTS
//   clk          in   1        single clock; all state changes on its rising edge
//   rst_n        in   1        asynchronous reset, active-low
//   if_req       in   1        fetch read request; held with if_addr until if_ack
//   if_addr      in   ADDR_W   fetch address
//   if_ack       out  1        one-cycle pulse: fetch access complete
//   if_rdata     out  RDATA_W  fetch read data; valid from the if_ack cycle, held until the next fetch ack
//   ls_req       in   1        load/store request; held with ls_we/ls_addr/ls_wdata until ls_ack
//   ls_we        in   1        1 = write, 0 = read
//   ls_addr      in   ADDR_W   load/store address
//   ls_wdata     in   WDATA_W  store data
//   ls_ack       out  1        one-cycle pulse: load/store access complete
//   ls_rdata     out  RDATA_W  load data; valid from the ls_ack cycle, held until the next load ack
//   maddr        out  ADDR_W   memory address
//   mrd          out  1        memory read strobe
//   mwr          out  1        memory write strobe
//   mwr_data     out  WDATA_W  memory write data
//   mdata        in   RDATA_W  memory read data
//   busy         out  1        high in every state except IDLE
// BEHAVIOUR
//   Reset: all outputs are 0; state = IDLE; last_gnt = LS, so fetch wins the first tie.
//   Reset mid-access deasserts mrd/mwr immediately (asynchronously). The in-flight access is lost and no ack is issued.
//   FSM states:
//   - IDLE: sample requests.
//     - Exactly one req: grant it.
//     - Both reqs: grant the requester that is not last_gnt.
//     - Grant action: latch addr, we and wdata; set last_gnt; cnt = 0; go to ACCESS.
//     - No req: stay in IDLE.
//   - ACCESS: drive maddr from the latched value. Assert mrd (read or fetch) or mwr (store).
//     - mrd and mwr are never high together. mwr_data is driven only for stores, else 0.
//     - cnt increments each cycle.
//     - When cnt == MEM_CYCLES-1: for reads, capture mdata into the granted rdata register; go to DONE.
//   - DONE: mrd = mwr = 0, maddr held. Pulse the granted ack for exactly 1 cycle. Go to IDLE.
//   Latency: req high at edge N in IDLE -> strobe high for cycles N+1..N+MEM_CYCLES -> ack in cycle N+MEM_CYCLES+1.
//   Minimum request-to-request spacing is MEM_CYCLES+2 cycles.
//   Requests are sampled only in IDLE.
//   - A req still high in the cycle after ack is treated as a new request.
//   - Dropping req or changing inputs during ACCESS/DONE has no effect; the access completes and ack still pulses.
//   Fetch is always a read; ls_we is ignored for fetch.
//   ls_rdata is unchanged by stores. if_rdata is unchanged by load/store accesses.
//   last_gnt updates only on grant, so alternation is strict under continuous contention.
//   Write data is zero-extended nowhere; the memory stores WDATA_W bits as is.
// STRUCTURE
//   Shared package mem_arb_pkg holds:
//   - state encoding localparams: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2
//   - requester IDs: REQ_IF = 1'b0, REQ_LS = 1'b1
//   - ADDR_W / WDATA_W / RDATA_W defaults
//   Sub-module rr_arb2: two-input round-robin picker (req[1:0], last_gnt in; gnt_id, gnt_valid out). It is combinational.
//   The FSM, access counter, latches and rdata registers live in mem_arbiter.
//   Bench reuses the existing behavioural memory model and connects it to maddr/mrd/mwr/mwr_data/mdata.
// TESTING (MEM_CYCLES = 2 unless stated)
//   1 Reset: rst_n = 0 mid-ACCESS of a store -> mwr, mrd, acks and busy go 0 within the same cycle, before the next edge.
//     After release, state is IDLE and no ack is seen.
//   2 Store then load: ls_we = 1, ls_addr = 8'h01, ls_wdata = 8'h5A ->
//     mwr high for 2 cycles with maddr = 01 and mwr_data = 5A; ls_ack 3 cycles after grant.
//     Then a load from 8'h01 -> ls_rdata = 16'h005A on ls_ack (memory model zero-pads).
//   3 Fetch read: if_addr = 8'h00 after a store of 8'h00 -> mrd high 2 cycles, no mwr.
//     if_ack pulses once with if_rdata = 16'h0000; ls_rdata is unchanged.
//   4 Contention: if_req and ls_req held high together for 4 accesses ->
//     grant order IF, LS, IF, LS; ack spacing is 4 cycles; no cycle has mrd and mwr both high.
//   5 Request withdrawn: ls_req dropped one cycle after grant -> access completes and ls_ack still pulses once.
//     Then IDLE with busy = 0.
//   6 MEM_CYCLES = 1 build: single-cycle strobe; ack 2 cycles after grant; back-to-back fetches at 8'h00 and 8'h01 return correct data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction-fetch / load-store memory arbiter.
// Holds the FSM encoding, requester IDs and default bus widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_WDATA_W = 8;
    localparam int DEF_RDATA_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: on a tie the requester that did not win last time is chosen.
// Purely combinational; the caller decides when to act on the grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        if (req[REQ_IF] && req[REQ_LS]) begin
            gnt_id = ~last_gnt;
        end else if (req[REQ_LS]) begin
            gnt_id = REQ_LS;
        end else begin
            gnt_id = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data memory between instruction fetch and load/store,
// holding each access for MEM_CYCLES cycles and returning data with a one-cycle ack.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int WDATA_W    = DEF_WDATA_W,
    parameter int RDATA_W    = DEF_RDATA_W,
    parameter int MEM_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic               if_ack,
    output logic [RDATA_W-1:0] if_rdata,
    input  logic               ls_req,
    input  logic               ls_we,
    input  logic [ADDR_W-1:0]  ls_addr,
    input  logic [WDATA_W-1:0] ls_wdata,
    output logic               ls_ack,
    output logic [RDATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0]  maddr,
    output logic               mrd,
    output logic               mwr,
    output logic [WDATA_W-1:0] mwr_data,
    input  logic [RDATA_W-1:0] mdata,
    output logic               busy
);

    localparam logic [3:0] CNT_LAST = 4'(MEM_CYCLES - 1);

    state_t             r_state;
    logic               r_last_gnt;
    logic               r_gnt_id;
    logic [3:0]         r_cnt;
    logic [ADDR_W-1:0]  r_maddr;
    logic               r_mrd;
    logic               r_mwr;
    logic [WDATA_W-1:0] r_mwr_data;
    logic               r_if_ack;
    logic               r_ls_ack;
    logic [RDATA_W-1:0] r_if_rdata;
    logic [RDATA_W-1:0] r_ls_rdata;
    logic               r_busy;

    logic               w_gnt_id;
    logic               w_gnt_valid;

    rr_arb2 u_rr_arb2 (
        .req       ({ls_req, if_req}),
        .last_gnt  (r_last_gnt),
        .gnt_id    (w_gnt_id),
        .gnt_valid (w_gnt_valid)
    );

    // Strobes are registers cleared by the async reset, so an in-flight access dies at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_gnt <= REQ_LS;
            r_gnt_id   <= REQ_IF;
            r_cnt      <= '0;
            r_maddr    <= '0;
            r_mrd      <= 1'b0;
            r_mwr      <= 1'b0;
            r_mwr_data <= '0;
            r_if_ack   <= 1'b0;
            r_ls_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt_id   <= w_gnt_id;
                        r_last_gnt <= w_gnt_id;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ACCESS;
                        if (w_gnt_id == REQ_IF) begin
                            r_maddr    <= if_addr;
                            r_mrd      <= 1'b1;
                            r_mwr      <= 1'b0;
                            r_mwr_data <= '0;
                        end else begin
                            r_maddr    <= ls_addr;
                            r_mrd      <= ~ls_we;
                            r_mwr      <= ls_we;
                            r_mwr_data <= ls_we ? ls_wdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == CNT_LAST) begin
                        if (r_mrd) begin
                            if (r_gnt_id == REQ_IF) r_if_rdata <= mdata;
                            else                    r_ls_rdata <= mdata;
                        end
                        r_if_ack   <= (r_gnt_id == REQ_IF);
                        r_ls_ack   <= (r_gnt_id == REQ_LS);
                        r_mrd      <= 1'b0;
                        r_mwr      <= 1'b0;
                        r_mwr_data <= '0;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_mrd   <= 1'b0;
                    r_mwr   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign maddr    = r_maddr;
    assign mrd      = r_mrd;
    assign mwr      = r_mwr;
    assign mwr_data = r_mwr_data;
    assign if_ack   = r_if_ack;
    assign ls_ack   = r_ls_ack;
    assign if_rdata = r_if_rdata;
    assign ls_rdata = r_ls_rdata;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_CYCLES=2 instance and a MEM_CYCLES=1 instance,
// each wired to a small behavioural memory that returns its byte zero-padded to 16 bits.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // MEM_CYCLES = 2 instance
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [7:0]  if_addr = 8'h00, ls_addr = 8'h00, ls_wdata = 8'h00;
    logic        if_ack, ls_ack, mrd, mwr, busy;
    logic [15:0] if_rdata, ls_rdata, mdata;
    logic [7:0]  maddr, mwr_data;
    logic [7:0]  mem [256];

    // MEM_CYCLES = 1 instance
    logic        b_if_req = 1'b0;
    logic [7:0]  b_if_addr = 8'h00;
    logic        b_if_ack, b_ls_ack, b_mrd, b_mwr, b_busy;
    logic [15:0] b_if_rdata, b_ls_rdata, b_mdata;
    logic [7:0]  b_maddr, b_mwr_data;
    logic [7:0]  b_mem [256];

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .maddr(maddr), .mrd(mrd), .mwr(mwr), .mwr_data(mwr_data), .mdata(mdata),
        .busy(busy)
    );

    mem_arbiter #(.MEM_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .ls_req(1'b0), .ls_we(1'b0), .ls_addr(8'h00), .ls_wdata(8'h00),
        .ls_ack(b_ls_ack), .ls_rdata(b_ls_rdata),
        .maddr(b_maddr), .mrd(b_mrd), .mwr(b_mwr), .mwr_data(b_mwr_data), .mdata(b_mdata),
        .busy(b_busy)
    );

    // Memory contents while reset is low: mem[i] = ~i, b_mem[i] = i ^ 8'h3C.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= ~8'(i);
        end else if (mwr) begin
            mem[maddr] <= mwr_data;
        end
    end
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) b_mem[i] <= 8'(i) ^ 8'h3C;
        end else if (b_mwr) begin
            b_mem[b_maddr] <= b_mwr_data;
        end
    end
    assign mdata   = {8'h00, mem[maddr]};
    assign b_mdata = {8'h00, b_mem[b_maddr]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if ({if_ack, ls_ack, mrd, mwr, busy, maddr, mwr_data, if_rdata, ls_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b/%b mrd=%b mwr=%b busy=%b maddr=%h, need all 0",
                     if_ack, ls_ack, mrd, mwr, busy, maddr);
        end
        rst_n = 1'b1;
        tick();
        ls_we = 1'b1; ls_addr = 8'h30; ls_wdata = 8'h77; ls_req = 1'b1;
        tick();
        checks++;
        if (mwr !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_store: mwr=%b busy=%b, need 1 1", mwr, busy);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({mwr, mrd, if_ack, ls_ack, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_async: mwr=%b mrd=%b acks=%b%b busy=%b, need 0", mwr, mrd, if_ack, ls_ack, busy);
        end
        ls_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({if_ack, ls_ack, busy, mwr, mrd} !== 5'b0) begin
                errors++;
                $display("FAIL reset_after_release c%0d: acks=%b%b busy=%b mwr=%b mrd=%b, need 0",
                         c, if_ack, ls_ack, busy, mwr, mrd);
            end
        end
    endtask

    task automatic test_store_load();
        ls_we = 1'b1; ls_addr = 8'h01; ls_wdata = 8'h5A; ls_req = 1'b1;
        tick();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (mwr !== 1'b1 || mrd !== 1'b0 || maddr !== 8'h01 || mwr_data !== 8'h5A || ls_ack !== 1'b0) begin
                errors++;
                $display("FAIL store_strobe c%0d: mwr=%b mrd=%b maddr=%h wdata=%h ack=%b, need 1 0 01 5a 0",
                         c, mwr, mrd, maddr, mwr_data, ls_ack);
            end
            tick();
        end
        checks++;
        if (ls_ack !== 1'b1 || mwr !== 1'b0 || maddr !== 8'h01) begin
            errors++;
            $display("FAIL store_ack: ls_ack=%b mwr=%b maddr=%h, need 1 0 01", ls_ack, mwr, maddr);
        end
        ls_req = 1'b0;
        tick();
        checks++;
        if (ls_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL store_done: ls_ack=%b busy=%b, need 0 0", ls_ack, busy);
        end
        ls_we = 1'b0; ls_req = 1'b1;
        tick();
        checks++;
        if (mrd !== 1'b1 || mwr !== 1'b0 || mwr_data !== 8'h00) begin
            errors++;
            $display("FAIL load_strobe: mrd=%b mwr=%b wdata=%h, need 1 0 00", mrd, mwr, mwr_data);
        end
        tick(); tick();
        checks++;
        if (ls_ack !== 1'b1 || ls_rdata !== 16'h005A) begin
            errors++;
            $display("FAIL load_data: ls_ack=%b ls_rdata=%h, need 1 005a", ls_ack, ls_rdata);
        end
        ls_req = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        ls_we = 1'b1; ls_addr = 8'h00; ls_wdata = 8'h00; ls_req = 1'b1;
        tick(); tick(); tick();
        ls_req = 1'b0; ls_we = 1'b0;
        tick();
        if_addr = 8'h00; if_req = 1'b1;
        tick();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (mrd !== 1'b1 || mwr !== 1'b0 || maddr !== 8'h00) begin
                errors++;
                $display("FAIL fetch_strobe c%0d: mrd=%b mwr=%b maddr=%h, need 1 0 00", c, mrd, mwr, maddr);
            end
            tick();
        end
        checks++;
        if (if_ack !== 1'b1 || ls_ack !== 1'b0 || if_rdata !== 16'h0000 || ls_rdata !== 16'h005A) begin
            errors++;
            $display("FAIL fetch_data: if_ack=%b ls_ack=%b if_rdata=%h ls_rdata=%h, need 1 0 0000 005a",
                     if_ack, ls_ack, if_rdata, ls_rdata);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if (if_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_single_pulse: if_ack=%b, need 0", if_ack);
        end
    endtask

    task automatic test_withdrawn();
        ls_we = 1'b0; ls_addr = 8'h02; ls_req = 1'b1;
        tick();
        ls_req = 1'b0; ls_addr = 8'h55;
        tick(); tick();
        checks++;
        if (ls_ack !== 1'b1 || ls_rdata !== 16'h00FD) begin
            errors++;
            $display("FAIL withdrawn_ack: ls_ack=%b ls_rdata=%h, need 1 00fd", ls_ack, ls_rdata);
        end
        tick();
        checks++;
        if (ls_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL withdrawn_idle: ls_ack=%b busy=%b, need 0 0", ls_ack, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || mrd !== 1'b0) begin
            errors++;
            $display("FAIL withdrawn_no_regrant: busy=%b mrd=%b, need 0 0", busy, mrd);
        end
    endtask

    task automatic test_contention();
        int n = 0;
        int last_c = 0;
        if_addr = 8'h10; ls_we = 1'b0; ls_addr = 8'h20;
        if_req = 1'b1; ls_req = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (mrd && mwr) begin
                checks++; errors++;
                $display("FAIL contention_strobes c%0d: mrd and mwr both high", c);
            end
            if (if_ack || ls_ack) begin
                checks++;
                if (ls_ack !== 1'(n % 2) || (if_ack && ls_ack)) begin
                    errors++;
                    $display("FAIL contention_order n%0d: if_ack=%b ls_ack=%b, need ls_ack=%0d", n, if_ack, ls_ack, n % 2);
                end
                checks++;
                if (if_ack && if_rdata !== 16'h00EF || ls_ack && ls_rdata !== 16'h00DF) begin
                    errors++;
                    $display("FAIL contention_data n%0d: if_rdata=%h ls_rdata=%h, need 00ef/00df", n, if_rdata, ls_rdata);
                end
                if (n > 0) begin
                    checks++;
                    if (c - last_c != 4) begin
                        errors++;
                        $display("FAIL contention_spacing n%0d: got %0d cycles, need 4", n, c - last_c);
                    end
                end
                last_c = c;
                n++;
                if (n == 4) begin
                    if_req = 1'b0; ls_req = 1'b0;
                end
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL contention_timeout: got %0d acks, need 4", n);
        end
        if_req = 1'b0; ls_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_single_cycle();
        b_if_addr = 8'h00; b_if_req = 1'b1;
        tick();
        checks++;
        if (b_mrd !== 1'b1 || b_maddr !== 8'h00 || b_if_ack !== 1'b0) begin
            errors++;
            $display("FAIL mc1_strobe0: mrd=%b maddr=%h ack=%b, need 1 00 0", b_mrd, b_maddr, b_if_ack);
        end
        tick();
        checks++;
        if (b_if_ack !== 1'b1 || b_if_rdata !== 16'h003C || b_mrd !== 1'b0) begin
            errors++;
            $display("FAIL mc1_ack0: ack=%b rdata=%h mrd=%b, need 1 003c 0", b_if_ack, b_if_rdata, b_mrd);
        end
        b_if_addr = 8'h01;
        tick(); tick();
        checks++;
        if (b_mrd !== 1'b1 || b_maddr !== 8'h01) begin
            errors++;
            $display("FAIL mc1_strobe1: mrd=%b maddr=%h, need 1 01", b_mrd, b_maddr);
        end
        tick();
        checks++;
        if (b_if_ack !== 1'b1 || b_if_rdata !== 16'h003D || b_ls_ack !== 1'b0 || b_mwr !== 1'b0) begin
            errors++;
            $display("FAIL mc1_ack1: ack=%b rdata=%h ls_ack=%b mwr=%b, need 1 003d 0 0",
                     b_if_ack, b_if_rdata, b_ls_ack, b_mwr);
        end
        b_if_req = 1'b0;
        tick(); tick();
        checks++;
        if (b_busy !== 1'b0 || b_if_ack !== 1'b0) begin
            errors++;
            $display("FAIL mc1_idle: busy=%b ack=%b, need 0 0", b_busy, b_if_ack);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_fetch();
        test_withdrawn();
        test_contention();
        test_single_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
